// File: rtl/stream_fifo.sv
// stream_fifo: synchronous valid/ready FIFO feeding the downstream buffer stage.
// Storage is one register per entry. All outputs come from registered state only,
// so no input reaches an output combinationally. Flush and reset both drain the
// queue at the clock edge and discard any handshake offered in that cycle.
module stream_fifo #(
  parameter int width        = 16,
  parameter int depth_log2   = 4,
  parameter int afull_margin = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic [width-1:0]      in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [width-1:0]      out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [depth_log2:0]   count,
  output logic                  almost_full
);

  localparam int depth = 1 << depth_log2;
  localparam logic [depth_log2:0] depth_cnt    = (depth_log2+1)'(depth);
  localparam logic [depth_log2:0] afull_thresh = (depth_log2+1)'(depth - afull_margin);

  logic [depth_log2-1:0] wr_ptr_reg, wr_ptr_next;
  logic [depth_log2-1:0] rd_ptr_reg, rd_ptr_next;
  logic [depth_log2:0]   count_reg, count_next;
  logic                  push;
  logic                  pop;
  logic                  accept;
  logic [depth*width-1:0] entries_flat;

  // Handshake qualifiers. in_ready deliberately ignores out_ready: a full FIFO
  // refuses the write even when the head word leaves in the same cycle.
  assign in_ready  = (count_reg != depth_cnt);
  assign out_valid = (count_reg != '0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;
  // Handshakes only take effect when neither reset nor flush is active.
  assign accept    = rst & ~flush;

  // Next-state for pointers and occupancy; reset and flush both drain.
  always_comb begin
    wr_ptr_next = wr_ptr_reg;
    rd_ptr_next = rd_ptr_reg;
    count_next  = count_reg;
    if (!accept) begin
      wr_ptr_next = '0;
      rd_ptr_next = '0;
      count_next  = '0;
    end else begin
      if (push) wr_ptr_next = wr_ptr_reg + 1'b1;
      if (pop)  rd_ptr_next = rd_ptr_reg + 1'b1;
      case ({push, pop})
        2'b10:   count_next = count_reg + 1'b1;
        2'b01:   count_next = count_reg - 1'b1;
        default: count_next = count_reg;
      endcase
    end
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk) begin
    wr_ptr_reg <= wr_ptr_next;
    rd_ptr_reg <= rd_ptr_next;
    count_reg  <= count_next;
  end

  // One storage word per entry; contents are never cleared, only overwritten.
  genvar gi;
  generate
    for (gi = 0; gi < depth; gi++) begin : g_entry
      logic [width-1:0] word_reg;

      // Capture the offered word when this entry is the write target.
      always_ff @(posedge clk) begin
        if (accept && push && (wr_ptr_reg == depth_log2'(gi)))
          word_reg <= in_data;
      end

      assign entries_flat[gi*width +: width] = word_reg;
    end
  endgenerate

  // Head word, masked to zero while empty so stale contents never leak out.
  always_comb begin
    out_data = '0;
    if (out_valid)
      out_data = entries_flat[rd_ptr_reg*width +: width];
  end

  assign count       = count_reg;
  assign almost_full = (count_reg >= afull_thresh);

endmodule

// File: tb/tb_stream_fifo.sv
// Bench for stream_fifo: a queue-based model checked every cycle on the falling
// edge, plus directed scenarios with literal expectations.
module tb_stream_fifo;

  localparam int W     = 16;
  localparam int DL2   = 4;
  localparam int DEPTH = 16;
  localparam int AFM   = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          flush;
  logic [W-1:0]  in_data;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  out_data;
  logic          out_valid;
  logic          out_ready;
  logic [DL2:0]  count;
  logic          almost_full;

  int checks = 0;
  int errors = 0;

  logic [W-1:0] model_q[$];
  bit           model_live = 0;

  stream_fifo #(.width(W), .depth_log2(DL2), .afull_margin(AFM)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .count(count), .almost_full(almost_full)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: a queue of accepted words, updated with the same edge's inputs.
  bit m_push, m_pop;
  always @(posedge clk) begin
    m_push = in_valid && (model_q.size() != DEPTH);
    m_pop  = out_ready && (model_q.size() != 0);
    if (!rst) begin
      model_q.delete();
      model_live = 1;
    end else if (flush) begin
      model_q.delete();
    end else begin
      if (m_pop)  void'(model_q.pop_front());
      if (m_push) model_q.push_back(in_data);
    end
  end

  // Compare process: every output against the model, away from the active edge.
  always @(negedge clk) begin
    if (model_live) begin
      chk("cmp_count", 32'(count), 32'(model_q.size()));
      chk("cmp_in_ready", 32'(in_ready), 32'(model_q.size() != DEPTH));
      chk("cmp_out_valid", 32'(out_valid), 32'(model_q.size() != 0));
      chk("cmp_out_data", 32'(out_data), (model_q.size() != 0) ? 32'(model_q[0]) : 32'd0);
      chk("cmp_almost_full", 32'(almost_full), 32'(model_q.size() >= DEPTH - AFM));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic iv, input logic [W-1:0] d, input logic ordy, input logic fl);
    in_valid  = iv;
    in_data   = d;
    out_ready = ordy;
    flush     = fl;
  endtask

  initial begin
    // Reset held three cycles while a word is offered.
    rst = 1'b0;
    drive(1'b1, 16'hBEEF, 1'b0, 1'b0);
    repeat (3) step();
    rst = 1'b1;
    drive(1'b0, 16'h0000, 1'b0, 1'b0);
    chk("rst_count", 32'(count), 0);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_out_data", 32'(out_data), 0);
    chk("rst_in_ready", 32'(in_ready), 1);
    chk("rst_almost_full", 32'(almost_full), 0);
    step();
    chk("rst_nothing_written", 32'(count), 0);
    $display("reset: count=%0d out_valid=%0d in_ready=%0d", count, out_valid, in_ready);

    // Fill to full with no consumer.
    for (int i = 1; i <= 16; i++) begin
      drive(1'b1, W'(i), 1'b0, 1'b0);
      step();
      chk("fill_count", 32'(count), 32'(i));
      chk("fill_afull", 32'(almost_full), 32'(i >= 14));
      $display("fill push %04h count=%0d almost_full=%0d", i, count, almost_full);
    end
    chk("full_in_ready", 32'(in_ready), 0);
    drive(1'b1, 16'h0011, 1'b0, 1'b0);
    step();
    chk("full_17th_refused", 32'(count), 16);
    $display("fill 17th offer count=%0d", count);

    // Drain and verify order.
    for (int i = 1; i <= 16; i++) begin
      drive(1'b0, 16'h0000, 1'b1, 1'b0);
      chk("drain_data", 32'(out_data), 32'(i));
      $display("drain pop %04h", out_data);
      step();
    end
    chk("drain_empty", 32'(count), 0);
    drive(1'b0, 16'h0000, 1'b0, 1'b0);

    // Build to five, then stream through for 40 cycles.
    for (int k = 0; k < 5; k++) begin
      drive(1'b1, W'(16'h0100 + k), 1'b0, 1'b0);
      step();
    end
    for (int k = 0; k < 40; k++) begin
      drive(1'b1, W'(16'h0200 + k), 1'b1, 1'b0);
      chk("stream_data", 32'(out_data), (k < 5) ? 32'(16'h0100 + k) : 32'(16'h0200 + k - 5));
      $display("stream pop %04h push %04h", out_data, in_data);
      step();
      chk("stream_count", 32'(count), 5);
    end
    for (int k = 0; k < 5; k++) begin
      drive(1'b0, 16'h0000, 1'b1, 1'b0);
      step();
    end
    chk("stream_drained", 32'(count), 0);

    // Full with simultaneous pop: pop happens, push refused that cycle.
    for (int k = 0; k < 16; k++) begin
      drive(1'b1, W'(16'h0300 + k), 1'b0, 1'b0);
      step();
    end
    drive(1'b1, 16'h03FF, 1'b1, 1'b0);
    step();
    chk("fullpop_count", 32'(count), 15);
    chk("fullpop_in_ready", 32'(in_ready), 1);
    chk("fullpop_head", 32'(out_data), 32'h0301);
    $display("full+pop count=%0d head=%04h", count, out_data);
    drive(1'b1, 16'h03FF, 1'b0, 1'b0);
    step();
    chk("fullpop_next_push", 32'(count), 16);
    for (int k = 0; k < 16; k++) begin
      drive(1'b0, 16'h0000, 1'b1, 1'b0);
      if (k == 15) chk("fullpop_last", 32'(out_data), 32'h03FF);
      step();
    end

    // Flush at count 9 with handshakes offered.
    for (int k = 0; k < 9; k++) begin
      drive(1'b1, W'(16'h0400 + k), 1'b0, 1'b0);
      step();
    end
    chk("pre_flush_count", 32'(count), 9);
    drive(1'b1, 16'h04FF, 1'b1, 1'b1);
    step();
    chk("flush_count", 32'(count), 0);
    chk("flush_out_valid", 32'(out_valid), 0);
    chk("flush_out_data", 32'(out_data), 0);
    drive(1'b1, 16'h00AA, 1'b0, 1'b0);
    step();
    chk("flush_first_out", 32'(out_data), 32'h00AA);
    chk("flush_count_one", 32'(count), 1);
    $display("flush then push: head=%04h count=%0d", out_data, count);
    drive(1'b0, 16'h0000, 1'b1, 1'b0);
    step();

    // Mid-operation reset discards queued words.
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, W'(16'h0500 + k), 1'b0, 1'b0);
      step();
    end
    rst = 1'b0;
    step();
    rst = 1'b1;
    drive(1'b1, 16'h0055, 1'b0, 1'b0);
    step();
    chk("midrst_first_out", 32'(out_data), 32'h0055);
    chk("midrst_count", 32'(count), 1);
    $display("mid reset then push: head=%04h count=%0d", out_data, count);

    // Random stress against the model.
    for (int c = 0; c < 10000; c++) begin
      drive(1'($urandom_range(1)), W'($urandom), 1'($urandom_range(1)), 1'b0);
      step();
    end
    $display("random stress: 10000 cycles, final count=%0d", count);

    drive(1'b0, 16'h0000, 1'b0, 1'b0);
    step();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
